// File: rtl/multi_pattern_detector_if.sv
// Bundle of configuration, sample and result signals for multi_pattern_detector.
// The master drives the table writes and input words; the slave (the detector) returns the match results.
interface multi_pattern_detector_if #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [W-1:0]     cfg_pat;
  logic [W-1:0]     cfg_mask;
  logic             cfg_ena;
  logic             in_valid;
  logic [W-1:0]     x;
  logic             clr_count;
  logic             z;
  logic [IW-1:0]    z_idx;
  logic             z_rise;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_ena, in_valid, x, clr_count,
    input  z, z_idx, z_rise, run_len, hit_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_ena, in_valid, x, clr_count,
    output z, z_idx, z_rise, run_len, hit_count
  );
endinterface

// File: rtl/multi_pattern_detector.sv
// Compares each valid input word against N programmable (pattern, mask, enable) entries
// and reports a registered match flag, lowest matching index, rising pulse, run length and hit count.
module multi_pattern_detector #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  multi_pattern_detector_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {NOMATCH = 1'b0, MATCH = 1'b1} state_t;

  logic [W-1:0]     pat_reg  [N];
  logic [W-1:0]     mask_reg [N];
  logic [N-1:0]     ena_reg;
  logic [N-1:0]     hit;
  logic             any_hit;
  logic [IW-1:0]    hit_idx;

  state_t           state_reg, state_next;
  logic [IW-1:0]    z_idx_reg, z_idx_next;
  logic             z_rise_reg, z_rise_next;
  logic [CNT_W-1:0] run_len_reg, run_len_next;
  logic [CNT_W-1:0] hit_count_reg, hit_count_next;

  // Each entry owns its storage; an out-of-range cfg_idx simply matches no entry.
  // Comparison reads the pre-write contents, so a same-cycle write only affects later words.
  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        pat_reg[gi]  <= '0;
        mask_reg[gi] <= '1;
        ena_reg[gi]  <= 1'b0;
      end else if (bus.cfg_we && (bus.cfg_idx == IW'(gi))) begin
        pat_reg[gi]  <= bus.cfg_pat;
        mask_reg[gi] <= bus.cfg_mask;
        ena_reg[gi]  <= bus.cfg_ena;
      end
    end

    assign hit[gi] = ena_reg[gi] & (((bus.x ^ pat_reg[gi]) & mask_reg[gi]) == '0);
  end

  assign any_hit = |hit;

  // Scan from the top so the lowest hitting index is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= NOMATCH;
      z_idx_reg     <= '0;
      z_rise_reg    <= 1'b0;
      run_len_reg   <= '0;
      hit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      z_idx_reg     <= z_idx_next;
      z_rise_reg    <= z_rise_next;
      run_len_reg   <= run_len_next;
      hit_count_reg <= hit_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    z_idx_next     = z_idx_reg;
    z_rise_next    = 1'b0;
    run_len_next   = run_len_reg;
    hit_count_next = hit_count_reg;

    if (bus.in_valid) begin
      if (any_hit) begin
        state_next     = MATCH;
        z_idx_next     = hit_idx;
        z_rise_next    = (state_reg == NOMATCH);
        run_len_next   = (run_len_reg == CNT_MAX) ? run_len_reg : run_len_reg + 1'b1;
        hit_count_next = (hit_count_reg == CNT_MAX) ? hit_count_reg : hit_count_reg + 1'b1;
      end else begin
        state_next   = NOMATCH;
        run_len_next = '0;
      end
    end

    // A clear request beats a simultaneous hit.
    if (bus.clr_count) hit_count_next = '0;
  end

  assign bus.z         = (state_reg == MATCH);
  assign bus.z_idx     = z_idx_reg;
  assign bus.z_rise    = z_rise_reg;
  assign bus.run_len   = run_len_reg;
  assign bus.hit_count = hit_count_reg;
endmodule

// File: tb/tb_multi_pattern_detector.sv
// Self-checking bench for multi_pattern_detector: directed table vectors, corner sequences,
// and randomized traffic compared against a behavioural model of the matching rules.
module tb_multi_pattern_detector;
  localparam int W     = 4;
  localparam int N     = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_pattern_detector_if #(.W(W), .N(N), .CNT_W(CNT_W)) bus ();

  multi_pattern_detector #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural reference state
  int m_pat  [N];
  int m_mask [N];
  bit m_ena  [N];
  bit m_z;
  int m_idx, m_run, m_hit;
  bit m_rise;

  typedef struct {
    logic [3:0] x;
    logic       z;
    int         idx;
    logic       rise;
    int         run;
    int         hit;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit we, input int idx, input int pat,
                            input int mask, input bit ena, input bit valid, input int xv,
                            input bit clr);
    int found;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pat[i] = 0; m_mask[i] = SAT; m_ena[i] = 0;
      end
      m_z = 0; m_idx = 0; m_rise = 0; m_run = 0; m_hit = 0;
      return;
    end
    found = -1;
    for (int i = 0; i < N; i++)
      if (found < 0 && m_ena[i] && (((xv ^ m_pat[i]) & m_mask[i]) == 0)) found = i;
    m_rise = 0;
    if (valid) begin
      m_rise = (found >= 0) && !m_z;
      m_z = (found >= 0);
      if (found >= 0) begin
        m_idx = found;
        m_run = (m_run + 1 > SAT) ? SAT : m_run + 1;
        m_hit = (m_hit + 1 > SAT) ? SAT : m_hit + 1;
      end else begin
        m_run = 0;
      end
    end
    if (clr) m_hit = 0;
    if (we && idx < N) begin
      m_pat[idx] = pat; m_mask[idx] = mask; m_ena[idx] = ena;
    end
  endtask

  // One clock of stimulus: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic step(input bit r, input bit we, input int idx, input int pat, input int mask,
                      input bit ena, input bit valid, input int xv, input bit clr);
    @(negedge clk);
    rst           = r;
    bus.cfg_we    = we;
    bus.cfg_idx   = idx[1:0];
    bus.cfg_pat   = pat[3:0];
    bus.cfg_mask  = mask[3:0];
    bus.cfg_ena   = ena;
    bus.in_valid  = valid;
    bus.x         = xv[3:0];
    bus.clr_count = clr;
    @(posedge clk);
    model_edge(r, we, idx, pat, mask, ena, valid, xv, clr);
    #1;
    check("model_z", bus.z, m_z);
    check("model_z_idx", bus.z_idx, m_idx);
    check("model_z_rise", bus.z_rise, m_rise);
    check("model_run_len", bus.run_len, m_run);
    check("model_hit_count", bus.hit_count, m_hit);
    $display("t=%0t rst=%0b we=%0b idx=%0d v=%0b x=%b clr=%0b -> z=%0b z_idx=%0d rise=%0b run=%0d hits=%0d",
             $time, r, we, idx, valid, xv[3:0], clr, bus.z, bus.z_idx, bus.z_rise,
             bus.run_len, bus.hit_count);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int idx, input int pat, input int mask, input bit ena);
    step(0, 1, idx, pat, mask, ena, 0, 0, 0);
  endtask

  task automatic sample(input int xv);
    step(0, 0, 0, 0, 0, 0, 1, xv, 0);
  endtask

  task automatic check_vec(input vec_t v, input int k);
    sample(int'(v.x));
    check($sformatf("tbl%0d_z", k), bus.z, v.z);
    check($sformatf("tbl%0d_idx", k), bus.z_idx, v.idx);
    check($sformatf("tbl%0d_rise", k), bus.z_rise, v.rise);
    check($sformatf("tbl%0d_run", k), bus.run_len, v.run);
    check($sformatf("tbl%0d_hit", k), bus.hit_count, v.hit);
  endtask

  initial begin
    // Legacy three-pattern set (entries 0..2)
    tbl[0] = '{x: 4'b1011, z: 1, idx: 0, rise: 1, run: 1, hit: 1};
    tbl[1] = '{x: 4'b0110, z: 1, idx: 1, rise: 0, run: 2, hit: 2};
    tbl[2] = '{x: 4'b0000, z: 0, idx: 1, rise: 0, run: 0, hit: 2};
    tbl[3] = '{x: 4'b0100, z: 1, idx: 2, rise: 1, run: 1, hit: 3};
    tbl[4] = '{x: 4'b1011, z: 1, idx: 0, rise: 0, run: 2, hit: 4};
    // Masked entry 3 only: pattern 1000, compare MSB
    tbl[5] = '{x: 4'b1111, z: 1, idx: 3, rise: 1, run: 1, hit: 1};
    tbl[6] = '{x: 4'b0111, z: 0, idx: 3, rise: 0, run: 0, hit: 1};
    tbl[7] = '{x: 4'b1001, z: 1, idx: 3, rise: 1, run: 1, hit: 2};

    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_pat = 0; bus.cfg_mask = 0; bus.cfg_ena = 0;
    bus.in_valid = 0; bus.x = 0; bus.clr_count = 0;

    do_reset();
    check("reset_z", bus.z, 0);
    check("reset_run", bus.run_len, 0);
    check("reset_hit", bus.hit_count, 0);

    cfg(0, 4'b1011, 4'b1111, 1);
    cfg(1, 4'b0110, 4'b1111, 1);
    cfg(2, 4'b0100, 4'b1111, 1);
    for (int k = 0; k < 5; k++) check_vec(tbl[k], k);

    do_reset();
    cfg(3, 4'b1000, 4'b1000, 1);
    for (int k = 5; k < 8; k++) check_vec(tbl[k], k);

    // Disable entry 0 in the same cycle it matches: old contents still win
    do_reset();
    cfg(0, 4'b0110, 4'b1111, 1);
    cfg(1, 4'b0110, 4'b1111, 1);
    step(0, 1, 0, 4'b0110, 4'b1111, 0, 1, 4'b0110, 0);
    check("race_idx_old", bus.z_idx, 0);
    sample(4'b0110);
    check("race_idx_new", bus.z_idx, 1);

    // Stall in MATCH with x toggling
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, int'($urandom_range(0, 15)), 0);
      check("stall_z", bus.z, 1);
      check("stall_rise", bus.z_rise, 0);
      check("stall_run", bus.run_len, 2);
      check("stall_hit", bus.hit_count, 2);
    end

    // Saturation, then clear colliding with a hit
    for (int k = 0; k < 20; k++) sample(4'b0110);
    check("sat_run", bus.run_len, SAT);
    check("sat_hit", bus.hit_count, SAT);
    step(0, 0, 0, 0, 0, 0, 1, 4'b0110, 1);
    check("clr_hit", bus.hit_count, 0);
    check("clr_run", bus.run_len, SAT);

    // Reset in the middle of a run
    do_reset();
    cfg(0, 4'b1011, 4'b1111, 1);
    for (int k = 0; k < 3; k++) sample(4'b1011);
    check("pre_rst_run", bus.run_len, 3);
    do_reset();
    check("mid_rst_z", bus.z, 0);
    check("mid_rst_run", bus.run_len, 0);
    check("mid_rst_hit", bus.hit_count, 0);
    sample(4'b1011);
    check("post_rst_z", bus.z, 0);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 300; k++) begin
      bit r, we, clr, ena, valid;
      int idx, pat, mask, xv;
      r     = ($urandom_range(0, 99) == 0);
      we    = ($urandom_range(0, 3) == 0);
      idx   = int'($urandom_range(0, N - 1));
      pat   = int'($urandom_range(0, 15));
      mask  = int'($urandom_range(0, 15) & $urandom_range(0, 15));
      ena   = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 3) != 0);
      xv    = int'($urandom_range(0, 15));
      clr   = ($urandom_range(0, 19) == 0);
      step(r, we, idx, pat, mask, ena, valid, xv, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
